// File: rtl/progmem_loader.sv
// Boot-time loader: parses a framed UART byte stream (sync, count, LE words, checksum)
// and writes each assembled 32-bit word into program memory while holding the CPU off.
module progmem_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [11:0] mem_address,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] mem_writedata,
    input  logic        mem_waitrequest,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error
);

    // state | meaning
    // IDLE  | hunting for SYNC_BYTE, all other bytes dropped
    // LEN0  | expecting word count low byte
    // LEN1  | expecting word count high byte
    // DATA  | collecting the 4 bytes of the next word
    // WRITE | word presented to memory until waitrequest is low
    // CSUM  | expecting the checksum byte
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LEN0  = 3'd1;
    localparam logic [2:0] LEN1  = 3'd2;
    localparam logic [2:0] DATA  = 3'd3;
    localparam logic [2:0] WRITE = 3'd4;
    localparam logic [2:0] CSUM  = 3'd5;

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    logic [2:0]  state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [12:0] idx_q, idx_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [7:0]  sum_q, sum_d;
    logic [11:0] mem_address_q, mem_address_d;
    logic        mem_write_q, mem_write_d;
    logic [3:0]  mem_byteenable_q, mem_byteenable_d;
    logic [31:0] mem_writedata_q, mem_writedata_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        load_done_q, load_done_d;
    logic        load_error_q, load_error_d;

    logic        accept;
    logic [15:0] len_full;
    logic [12:0] idx_next;

    assign rx_ready = (state_q != WRITE);
    assign accept   = rx_valid && rx_ready;
    assign len_full = {rx_data, len_q[7:0]};
    assign idx_next = idx_q + 13'd1;

    always_comb begin
        state_d          = state_q;
        len_d            = len_q;
        idx_d            = idx_q;
        bcnt_d           = bcnt_q;
        sum_d            = sum_q;
        mem_address_d    = mem_address_q;
        mem_write_d      = mem_write_q;
        mem_byteenable_d = mem_byteenable_q;
        mem_writedata_d  = mem_writedata_q;
        cpu_hold_d       = cpu_hold_q;
        load_done_d      = 1'b0;
        load_error_d     = load_error_q;

        case (state_q)
            IDLE: begin
                if (accept && (rx_data == SYNC_BYTE)) begin
                    state_d      = LEN0;
                    cpu_hold_d   = 1'b1;
                    load_error_d = 1'b0;
                    sum_d        = 8'h00;
                    bcnt_d       = 2'd0;
                    idx_d        = 13'd0;
                end
            end
            LEN0: begin
                if (accept) begin
                    len_d[7:0] = rx_data;
                    state_d    = LEN1;
                end
            end
            LEN1: begin
                if (accept) begin
                    len_d = len_full;
                    if (len_full == 16'd0) begin
                        state_d = CSUM;
                    end else if ({1'b0, len_full} > MAX_LEN) begin
                        load_error_d = 1'b1;
                        cpu_hold_d   = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    case (bcnt_q)
                        2'd0: mem_writedata_d[7:0]   = rx_data;
                        2'd1: mem_writedata_d[15:8]  = rx_data;
                        2'd2: mem_writedata_d[23:16] = rx_data;
                        default: mem_writedata_d[31:24] = rx_data;
                    endcase
                    sum_d  = sum_q + rx_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d          = WRITE;
                        mem_write_d      = 1'b1;
                        mem_byteenable_d = 4'hF;
                        mem_address_d    = idx_q[11:0];
                    end
                end
            end
            WRITE: begin
                if (!mem_waitrequest) begin
                    mem_write_d      = 1'b0;
                    mem_byteenable_d = 4'h0;
                    idx_d            = idx_next;
                    // len_q never exceeds MAX_WORDS here, so 13 bits cover it
                    state_d = (idx_next == len_q[12:0]) ? CSUM : DATA;
                end
            end
            CSUM: begin
                if (accept) begin
                    if (rx_data == sum_q) load_done_d  = 1'b1;
                    else                  load_error_d = 1'b1;
                    cpu_hold_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            len_q            <= 16'd0;
            idx_q            <= 13'd0;
            bcnt_q           <= 2'd0;
            sum_q            <= 8'h00;
            mem_address_q    <= 12'd0;
            mem_write_q      <= 1'b0;
            mem_byteenable_q <= 4'h0;
            mem_writedata_q  <= 32'h0;
            cpu_hold_q       <= 1'b0;
            load_done_q      <= 1'b0;
            load_error_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            len_q            <= len_d;
            idx_q            <= idx_d;
            bcnt_q           <= bcnt_d;
            sum_q            <= sum_d;
            mem_address_q    <= mem_address_d;
            mem_write_q      <= mem_write_d;
            mem_byteenable_q <= mem_byteenable_d;
            mem_writedata_q  <= mem_writedata_d;
            cpu_hold_q       <= cpu_hold_d;
            load_done_q      <= load_done_d;
            load_error_q     <= load_error_d;
        end
    end

    assign mem_address    = mem_address_q;
    assign mem_write      = mem_write_q;
    assign mem_byteenable = mem_byteenable_q;
    assign mem_writedata  = mem_writedata_q;
    assign cpu_hold       = cpu_hold_q;
    assign load_done      = load_done_q;
    assign load_error     = load_error_q;

endmodule

// File: tb/tb_progmem_loader.sv
// Scoreboard bench for progmem_loader: expected writes are queued by the stimulus,
// a negedge monitor compares every cycle the DUT drives mem_write.
module tb_progmem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [11:0] mem_address;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic        mem_waitrequest = 1'b0;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    int tests = 0;
    int fails = 0;
    int stall_len = 0;
    int stall_cnt = 0;
    int wr_cycles = 0;
    int done_cnt = 0;

    logic [43:0] exp_q[$];

    progmem_loader dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_address(mem_address), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .mem_waitrequest(mem_waitrequest),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory stall model: waitrequest high for stall_len cycles of each write.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mem_write && stall_cnt < stall_len) begin
                mem_waitrequest = 1'b1;
                stall_cnt++;
            end else begin
                mem_waitrequest = 1'b0;
                if (!mem_write) stall_cnt = 0;
            end
        end
    end

    // Monitor: every write-active cycle must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (load_done) begin
                    done_cnt++;
                    check("hold_low_at_done", {31'd0, cpu_hold}, 32'd0);
                end
                if (mem_write) begin
                    wr_cycles++;
                    check("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
                    check("byteenable", {28'd0, mem_byteenable}, 32'hF);
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none",
                                 mem_address, mem_writedata);
                    end else begin
                        check("wr_addr", {20'd0, mem_address}, {20'd0, exp_q[0][43:32]});
                        check("wr_data", mem_writedata, exp_q[0][31:0]);
                        if (!mem_waitrequest) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rx_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        rx_valid = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL byte_timeout: byte 0x%0h not accepted, expected acceptance", b);
        end
    endtask

    task automatic push_write(input logic [11:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Frame body after sync: count 2, two words, given checksum.
    task automatic send_two_word_body(input logic [7:0] csum);
        logic [7:0] body[11];
        body = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                 8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
        body[10] = csum;
        for (int i = 0; i < 11; i++) send_byte(body[i]);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        int wc0;
        int dc0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check("rst_addr", {20'd0, mem_address}, 32'd0);
        check("rst_be", {28'd0, mem_byteenable}, 32'd0);
        check("rst_wdata", mem_writedata, 32'd0);
        check("rst_hold_done_err", {29'd0, cpu_hold, load_done, load_error}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(2);

        // Good frame, no stall
        stall_len = 0;
        dc0 = done_cnt;
        wc0 = wr_cycles;
        push_write(12'd0, 32'h44332211);
        push_write(12'd1, 32'h88776655);
        send_byte(8'hA5);
        check("t1_hold_after_sync", {31'd0, cpu_hold}, 32'd1);
        send_two_word_body(8'h64);
        check("t1_done", {31'd0, load_done}, 32'd1);
        check("t1_error", {31'd0, load_error}, 32'd0);
        check("t1_hold_fall", {31'd0, cpu_hold}, 32'd0);
        idle_cycles(1);
        check("t1_done_one_cycle", {31'd0, load_done}, 32'd0);
        check("t1_done_count", done_cnt - dc0, 1);
        check("t1_write_cycles", wr_cycles - wc0, 2);
        check("t1_queue_empty", exp_q.size(), 0);

        // Same frame, 6-cycle stall per write
        stall_len = 6;
        dc0 = done_cnt;
        wc0 = wr_cycles;
        push_write(12'd0, 32'h44332211);
        push_write(12'd1, 32'h88776655);
        send_byte(8'hA5);
        send_two_word_body(8'h64);
        check("t2_done", {31'd0, load_done}, 32'd1);
        idle_cycles(1);
        check("t2_done_count", done_cnt - dc0, 1);
        check("t2_write_cycles", wr_cycles - wc0, 14);
        check("t2_queue_empty", exp_q.size(), 0);

        // Bad checksum
        stall_len = 0;
        dc0 = done_cnt;
        push_write(12'd0, 32'h44332211);
        push_write(12'd1, 32'h88776655);
        send_byte(8'hA5);
        send_two_word_body(8'h65);
        check("t3_error", {31'd0, load_error}, 32'd1);
        check("t3_hold", {31'd0, cpu_hold}, 32'd0);
        idle_cycles(2);
        check("t3_no_done", done_cnt - dc0, 0);
        check("t3_queue_empty", exp_q.size(), 0);

        // Oversized count 0x1001, then resync with an empty frame
        send_byte(8'hA5);
        check("t4_sync_clears_err", {31'd0, load_error}, 32'd0);
        send_byte(8'h01);
        send_byte(8'h10);
        check("t4_len_error", {31'd0, load_error}, 32'd1);
        check("t4_hold_drop", {31'd0, cpu_hold}, 32'd0);
        send_byte(8'hA5);
        check("t4_resync_err", {31'd0, load_error}, 32'd0);
        check("t4_resync_hold", {31'd0, cpu_hold}, 32'd1);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        check("t4_empty_done", {31'd0, load_done}, 32'd1);

        // Garbage before sync, empty frame
        idle_cycles(1);
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        check("t5_garbage_ignored", {31'd0, cpu_hold}, 32'd0);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        check("t5_done", {31'd0, load_done}, 32'd1);
        check("t5_error", {31'd0, load_error}, 32'd0);
        idle_cycles(1);
        check("t5_no_writes", exp_q.size(), 0);

        // Reset during the second write
        stall_len = 3;
        push_write(12'd0, 32'h44332211);
        push_write(12'd1, 32'h88776655);
        send_byte(8'hA5);
        for (int i = 0; i < 2; i++) send_byte(i == 0 ? 8'h02 : 8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        #1;
        check("t6_write_active", {31'd0, mem_write}, 32'd1);
        check("t6_first_written", exp_q.size(), 1);
        rst = 1'b1;
        #1;
        check("t6_rst_write", {31'd0, mem_write}, 32'd0);
        check("t6_rst_ready", {31'd0, rx_ready}, 32'd1);
        check("t6_rst_hold", {31'd0, cpu_hold}, 32'd0);
        check("t6_rst_addr_data", {20'd0, mem_address} | mem_writedata, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(2);
        stall_len = 0;
        dc0 = done_cnt;
        push_write(12'd0, 32'h44332211);
        push_write(12'd1, 32'h88776655);
        send_byte(8'hA5);
        send_two_word_body(8'h64);
        check("t6_reload_done", {31'd0, load_done}, 32'd1);
        idle_cycles(1);
        check("t6_reload_count", done_cnt - dc0, 1);
        check("t6_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/progmem_loader.md
# progmem_loader

Boot-time program loader sitting directly upstream of the program memory wrapper on its control (write) port. It takes a byte stream from the UART receiver, parses a framed image (sync byte, word count, little-endian words, checksum), and issues one 32-bit full-word write per received word into the 16 KB program memory. While a load is in progress it holds the CPU off the memory, and it reports completion or error.

## Interface
Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_WORDS, 4096, largest legal word count, equal to program memory depth.

Ports:
- clk  in  1  system clock; the block uses this single clock.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte; a transfer happens when rx_valid and rx_ready are both high.
- mem_address  out  12  word address into program memory.
- mem_write  out  1  write request.
- mem_byteenable  out  4  always 4'hF while mem_write is high, otherwise 4'h0.
- mem_writedata  out  32  assembled word.
- mem_waitrequest  in  1  memory stall.
- cpu_hold  out  1  high while a frame is being loaded.
- load_done  out  1  one-cycle pulse when a frame completes with a good checksum.
- load_error  out  1  sticky error flag; cleared when the next SYNC_BYTE is accepted.

## Operation
- States: IDLE, LEN0, LEN1, DATA, WRITE, CSUM.
- IDLE:
  - rx_ready=1.
  - Bytes other than SYNC_BYTE are discarded.
  - SYNC_BYTE moves to LEN0, sets cpu_hold=1, clears load_error, the 8-bit sum, the byte counter and the word index.
- LEN0 / LEN1: take the count low byte, then the high byte, into a 16-bit count N.
  - N==0: go to CSUM.
  - N>MAX_WORDS: set load_error, clear cpu_hold, go to IDLE.
  - Otherwise: go to DATA.
- DATA:
  - rx_ready=1. Bytes fill mem_writedata little-endian: the first byte goes to [7:0], the fourth to [31:24].
  - Every data byte is added to the 8-bit sum, modulo 256.
  - On the 4th byte, go to WRITE.
- WRITE:
  - rx_ready=0, mem_write=1, mem_address = word index, data held stable.
  - The write completes in the cycle mem_waitrequest=0.
  - On completion, increment the word index. Go to CSUM if the index reaches N, else go to DATA.
- CSUM: take one byte.
  - Byte equals the sum: pulse load_done.
  - Byte differs: set load_error.
  - Either way, clear cpu_hold and go to IDLE.
- Words already written stay in memory on error. No rollback.

## Timing
- Reset values:
  - state=IDLE, rx_ready=1, mem_write=0, mem_address=0, mem_byteenable=0, mem_writedata=0.
  - cpu_hold=0, load_done=0, load_error=0.
- All outputs are registered except rx_ready, which is decoded from state.
- mem_write rises in the cycle after the 4th byte of a word is accepted.
- mem_write falls in the cycle after the one where mem_write=1 and mem_waitrequest=0.
  - Minimum write occupancy is 1 cycle.
  - Occupancy is unbounded while waitrequest stays high.
- rx_ready returns to 1 in that same following cycle.
- load_done is high for exactly 1 cycle, the one after the checksum byte is accepted. cpu_hold falls in that same cycle.
- Reset mid-frame: everything returns to reset values immediately. A write in flight is abandoned.
- A SYNC_BYTE value arriving inside LEN, DATA or CSUM is treated as data, not as a resync.
- Word index is 13 bits, so N=4096 is legal. mem_address carries the index [11:0].

## Test plan
- Frame A5, 02 00, 11 22 33 44, 55 66 77 88, then checksum 0x64:
  - two writes: addr 0 data 0x44332211, addr 1 data 0x88776655, byteenable F;
  - load_done pulses once, load_error=0, cpu_hold high from the cycle after the A5 until the done cycle.
- Same frame with mem_waitrequest held high for 6 cycles per write:
  - mem_write and data stay stable through the stall;
  - rx_ready=0 through the stall;
  - the bytes stall upstream and none are lost.
- Same frame with checksum 0x65: both words are written, load_error=1, no load_done pulse, cpu_hold=0.
- Count 0x1001:
  - load_error=1 right after the LEN1 byte;
  - no mem_write;
  - the next byte A5 is accepted as a sync and clears load_error.
- Garbage bytes 00 FF 5A before A5, 00 00, then 00: all ignored, then load_done pulses with no writes.
- Assert rst while mem_write=1 in the second word: mem_write drops immediately, state is IDLE, and a following good frame loads correctly.
